// File: rtl/jtkunio_colmix_pkg.sv
// Shared constants and the layer priority helper for the Kunio colour mixer.
package jtkunio_colmix_pkg;

  localparam logic [2:0]  CHAR_BASE  = 3'b000;
  localparam logic [2:0]  OBJ_BASE   = 3'b100;
  localparam logic [1:0]  SCR_BASE   = 2'b11;
  localparam int unsigned BANK_BIT   = 8;
  localparam logic [2:0]  TRANSP_COL = 3'd0;

  typedef enum logic [1:0] {LyrNone, LyrChar, LyrObj, LyrScr} layer_e;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  // Char over obj over scroll; scroll only drops out through its enable bit.
  function automatic logic [7:0] sel_index(input logic [4:0] obj, input logic [4:0] chr,
                                           input logic [5:0] scr, input logic [2:0] en);
    layer_e     lyr;
    logic [7:0] idx;
    if (en[0] && chr[2:0] != TRANSP_COL) begin
      lyr = LyrChar;
    end else if (en[1] && obj[2:0] != TRANSP_COL) begin
      lyr = LyrObj;
    end else if (en[2]) begin
      lyr = LyrScr;
    end else begin
      lyr = LyrNone;
    end
    unique case (lyr)
      LyrChar: idx = {CHAR_BASE, chr};
      LyrObj:  idx = {OBJ_BASE, obj};
      LyrScr:  idx = {SCR_BASE, scr};
      default: idx = 8'h00;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/jtframe_dual_ram.sv
// Two-port synchronous RAM, single clock, registered reads on both ports.
module jtframe_dual_ram #(
  parameter int unsigned Dw = 8,
  parameter int unsigned Aw = 8
) (
  input  logic          clk_i,
  input  logic [Dw-1:0] data0_i,
  input  logic [Aw-1:0] addr0_i,
  input  logic          we0_i,
  output logic [Dw-1:0] q0_o,
  input  logic [Dw-1:0] data1_i,
  input  logic [Aw-1:0] addr1_i,
  input  logic          we1_i,
  output logic [Dw-1:0] q1_o
);

  logic [Dw-1:0] mem [2**Aw];

  always_ff @(posedge clk_i) begin
    if (we0_i) mem[addr0_i] <= data0_i;
    if (we1_i) mem[addr1_i] <= data1_i;
    q0_o <= mem[addr0_i];
    q1_o <= mem[addr1_i];
  end

endmodule

// File: rtl/jtkunio_colmix.sv
// Kunio final video stage: layer priority, palette lookup, registered RGB and delayed blanking.
module jtkunio_colmix
  import jtkunio_colmix_pkg::*;
#(
  parameter int unsigned BLANK_DLY = 2
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       pxl_cen,
  input  logic       LHBL,
  input  logic       LVBL,
  input  logic [4:0] obj_pxl,
  input  logic [4:0] char_pxl,
  input  logic [5:0] scr_pxl,
  input  logic [2:0] gfx_en,
  input  logic [8:0] cpu_addr,
  input  logic       pal_cs,
  input  logic       cpu_wrn,
  input  logic [7:0] cpu_dout,
  output logic [7:0] cpu_din,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       LHBL_dly,
  output logic       LVBL_dly
);

  logic [7:0]           pal_idx_d, pal_idx_q;
  logic [7:0]           rg_cpu, b_cpu, rg_vid, b_vid;
  logic                 bank_q;
  logic                 cpu_we, we_rg, we_b;
  logic [BLANK_DLY-1:0] hb_q, vb_q;
  logic [BLANK_DLY:0]   hb_ext, vb_ext;
  rgb_t                 rgb_d, rgb_q;
  logic                 unused_b_hi;

  assign cpu_we = pal_cs & ~cpu_wrn;
  assign we_rg  = cpu_we & ~cpu_addr[BANK_BIT];
  assign we_b   = cpu_we &  cpu_addr[BANK_BIT];

  jtframe_dual_ram #(.Dw(8), .Aw(8)) u_rg_ram (
    .clk_i   (clk),
    .data0_i (cpu_dout),
    .addr0_i (cpu_addr[7:0]),
    .we0_i   (we_rg),
    .q0_o    (rg_cpu),
    .data1_i (8'h00),
    .addr1_i (pal_idx_q),
    .we1_i   (1'b0),
    .q1_o    (rg_vid)
  );

  jtframe_dual_ram #(.Dw(8), .Aw(8)) u_b_ram (
    .clk_i   (clk),
    .data0_i (cpu_dout),
    .addr0_i (cpu_addr[7:0]),
    .we0_i   (we_b),
    .q0_o    (b_cpu),
    .data1_i (8'h00),
    .addr1_i (pal_idx_q),
    .we1_i   (1'b0),
    .q1_o    (b_vid)
  );

  // Bank select is registered so the mux tracks the RAM's one-clk read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bank_q <= 1'b0;
    else     bank_q <= cpu_addr[BANK_BIT];
  end

  assign cpu_din     = bank_q ? b_cpu : rg_cpu;
  assign unused_b_hi = ^b_vid[7:4];

  always_comb begin
    pal_idx_d = sel_index(obj_pxl, char_pxl, scr_pxl, gfx_en);
    hb_ext    = {hb_q, LHBL};
    vb_ext    = {vb_q, LVBL};
    rgb_d     = '0;
    // Gate with the blanking values that will leave alongside this pixel.
    if (hb_ext[BLANK_DLY-1] && vb_ext[BLANK_DLY-1]) begin
      rgb_d = '{r: rg_vid[3:0], g: rg_vid[7:4], b: b_vid[3:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pal_idx_q <= 8'h00;
      hb_q      <= '0;
      vb_q      <= '0;
      rgb_q     <= '0;
    end else if (pxl_cen) begin
      pal_idx_q <= pal_idx_d;
      hb_q      <= hb_ext[BLANK_DLY-1:0];
      vb_q      <= vb_ext[BLANK_DLY-1:0];
      rgb_q     <= rgb_d;
    end
  end

  assign red      = rgb_q.r;
  assign green    = rgb_q.g;
  assign blue     = rgb_q.b;
  assign LHBL_dly = hb_q[BLANK_DLY-1];
  assign LVBL_dly = vb_q[BLANK_DLY-1];

endmodule

// File: tb/tb_jtkunio_colmix.sv
// Directed bench for jtkunio_colmix with a palette model and an expected-pixel queue.
module tb_jtkunio_colmix;

  logic       rst, clk, pxl_cen, LHBL, LVBL;
  logic [4:0] obj_pxl, char_pxl;
  logic [5:0] scr_pxl;
  logic [2:0] gfx_en;
  logic [8:0] cpu_addr;
  logic       pal_cs, cpu_wrn;
  logic [7:0] cpu_dout, cpu_din;
  logic [3:0] red, green, blue;
  logic       LHBL_dly, LVBL_dly;

  typedef struct packed {
    logic [11:0] rgb;
    logic        hb;
    logic        vb;
  } exp_t;

  exp_t       sb[$];
  exp_t       last_exp;
  logic [7:0] rg_m [256];
  logic [7:0] b_m  [256];
  int         checks   = 0;
  int         failures = 0;

  jtkunio_colmix #(.BLANK_DLY(2)) dut (
    .rst      (rst),
    .clk      (clk),
    .pxl_cen  (pxl_cen),
    .LHBL     (LHBL),
    .LVBL     (LVBL),
    .obj_pxl  (obj_pxl),
    .char_pxl (char_pxl),
    .scr_pxl  (scr_pxl),
    .gfx_en   (gfx_en),
    .cpu_addr (cpu_addr),
    .pal_cs   (pal_cs),
    .cpu_wrn  (cpu_wrn),
    .cpu_dout (cpu_dout),
    .cpu_din  (cpu_din),
    .red      (red),
    .green    (green),
    .blue     (blue),
    .LHBL_dly (LHBL_dly),
    .LVBL_dly (LVBL_dly)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mdl_idx(input logic [4:0] c, input logic [4:0] o,
                                         input logic [5:0] s, input logic [2:0] g);
    if (g[0] && c[2:0] != 3'd0) return {3'b000, c};
    if (g[1] && o[2:0] != 3'd0) return {3'b100, o};
    if (g[2])                   return {2'b11, s};
    return 8'h00;
  endfunction

  task automatic tick();
    repeat (3) @(negedge clk);
    pxl_cen = 1'b1;
    @(negedge clk);
    pxl_cen = 1'b0;
  endtask

  task automatic cpu_wr(input logic [8:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_addr = a; cpu_dout = d; pal_cs = 1'b1; cpu_wrn = 1'b0;
    @(negedge clk);
    pal_cs = 1'b0; cpu_wrn = 1'b1;
    if (a[8]) b_m[a[7:0]] = d;
    else      rg_m[a[7:0]] = d;
  endtask

  task automatic cpu_rd(input string tag, input logic [8:0] a);
    logic [7:0] e;
    @(negedge clk);
    cpu_addr = a; pal_cs = 1'b1; cpu_wrn = 1'b1;
    @(negedge clk);
    e = a[8] ? b_m[a[7:0]] : rg_m[a[7:0]];
    chk(tag, {24'd0, cpu_din}, {24'd0, e});
    pal_cs = 1'b0;
  endtask

  task automatic pix(input string tag, input logic [4:0] c, input logic [4:0] o,
                     input logic [5:0] s, input logic [2:0] g, input logic hb, input logic vb);
    exp_t       e;
    logic [7:0] i;
    i     = mdl_idx(c, o, s, g);
    e.rgb = (hb && vb) ? {rg_m[i][3:0], rg_m[i][7:4], b_m[i][3:0]} : 12'h000;
    e.hb  = hb;
    e.vb  = vb;
    char_pxl = c; obj_pxl = o; scr_pxl = s; gfx_en = g; LHBL = hb; LVBL = vb;
    sb.push_back(e);
    tick();
    if (sb.size() >= 2) begin
      e = sb.pop_front();
      last_exp = e;
      chk({tag, "_rgb"}, {20'd0, red, green, blue}, {20'd0, e.rgb});
      chk({tag, "_hb"}, {31'd0, LHBL_dly}, {31'd0, e.hb});
      chk({tag, "_vb"}, {31'd0, LVBL_dly}, {31'd0, e.vb});
    end
  endtask

  initial begin
    rst = 1'b1; pxl_cen = 1'b0; LHBL = 1'b1; LVBL = 1'b1;
    obj_pxl = '0; char_pxl = '0; scr_pxl = '0; gfx_en = 3'b111;
    cpu_addr = '0; pal_cs = 1'b0; cpu_wrn = 1'b1; cpu_dout = '0;
    last_exp = '0;
    repeat (2) @(negedge clk);
    chk("rst_rgb", {20'd0, red, green, blue}, 32'd0);
    chk("rst_hb", {31'd0, LHBL_dly}, 32'd0);
    chk("rst_vb", {31'd0, LVBL_dly}, 32'd0);
    rst = 1'b0;

    cpu_wr(9'h013, 8'h5A); cpu_wr(9'h113, 8'h0C);
    cpu_wr(9'h08A, 8'h3F); cpu_wr(9'h18A, 8'h07);
    cpu_wr(9'h0EB, 8'h21); cpu_wr(9'h1EB, 8'h09);
    cpu_wr(9'h000, 8'hDB); cpu_wr(9'h100, 8'h0E);
    cpu_wr(9'h005, 8'hFF); cpu_wr(9'h105, 8'hFF);
    cpu_rd("rd_rg13", 9'h013);
    cpu_rd("rd_b13", 9'h113);
    cpu_rd("rd_b05", 9'h105);

    pix("fill",   5'h13, 5'h0A, 6'h21, 3'b111, 1'b1, 1'b1);
    pix("char",   5'h10, 5'h0A, 6'h21, 3'b111, 1'b1, 1'b1);
    pix("obj",    5'h13, 5'h0A, 6'h21, 3'b110, 1'b1, 1'b1);
    pix("objen",  5'h00, 5'h00, 6'h2B, 3'b111, 1'b1, 1'b1);
    pix("scr",    5'h00, 5'h00, 6'h2B, 3'b011, 1'b1, 1'b1);
    pix("none",   5'h05, 5'h00, 6'h00, 3'b111, 1'b1, 1'b1);
    pix("white",  5'h13, 5'h00, 6'h00, 3'b111, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) pix("hblank", 5'h13, 5'h00, 6'h00, 3'b111, 1'b0, 1'b1);
    pix("hbend",  5'h13, 5'h00, 6'h00, 3'b111, 1'b1, 1'b1);
    pix("hbend2", 5'h13, 5'h00, 6'h00, 3'b111, 1'b1, 1'b0);
    pix("vblank", 5'h05, 5'h00, 6'h00, 3'b111, 1'b1, 1'b1);
    pix("vbend",  5'h05, 5'h00, 6'h00, 3'b111, 1'b1, 1'b1);
    pix("white2", 5'h05, 5'h00, 6'h00, 3'b111, 1'b1, 1'b1);

    // Video side must hold while pxl_cen stays low, even with new pixels on the inputs.
    char_pxl = 5'h13; LHBL = 1'b0;
    repeat (10) @(negedge clk);
    chk("hold_rgb", {20'd0, red, green, blue}, {20'd0, last_exp.rgb});
    chk("hold_hb", {31'd0, LHBL_dly}, {31'd0, last_exp.hb});

    rst = 1'b1;
    #1;
    chk("arst_rgb", {20'd0, red, green, blue}, 32'd0);
    chk("arst_hb", {31'd0, LHBL_dly}, 32'd0);
    chk("arst_vb", {31'd0, LVBL_dly}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    pix("rel1", 5'h05, 5'h00, 6'h00, 3'b111, 1'b1, 1'b1);
    chk("rel1_rgb", {20'd0, red, green, blue}, 32'd0);
    pix("rel2", 5'h05, 5'h00, 6'h00, 3'b111, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtkunio_colmix.md
Name: jtkunio_colmix

Overview:
- Final video stage of the Kunio core, directly downstream of the object, character and scroll layer generators.
- Resolves layer priority and transparency on the 5-bit object pixel, character pixel and scroll pixel.
- Looks the winning index up in CPU-writable palette RAM and emits registered 4-bit RGB with delayed blanking.
- The CPU reads and writes the palette through a dedicated port.

Parameters:
- BLANK_DLY, 2: pipeline depth in pxl_cen ticks applied to LHBL/LVBL so they align with RGB.

Ports:
- rst  in  1  reset, asynchronous, active-high
- clk  in  1  system clock
- pxl_cen  in  1  pixel clock enable; one clk wide
- LHBL  in  1  horizontal blank, active low
- LVBL  in  1  vertical blank, active low
- obj_pxl  in  5  object pixel {pal[1:0], col[2:0]}
- char_pxl  in  5  character pixel {pal[1:0], col[2:0]}
- scr_pxl  in  6  scroll pixel {pal[2:0], col[2:0]}
- gfx_en  in  3  debug layer enables {scr, obj, char}; a 0 bit forces that layer transparent
- cpu_addr  in  9  palette address; bit 8 = 0 selects RG bank, 1 selects B bank
- pal_cs  in  1  palette chip select
- cpu_wrn  in  1  write strobe, active low
- cpu_dout  in  8  CPU write data
- cpu_din  out  8  CPU read data; bank selected by cpu_addr[8]
- red  out  4  red output
- green  out  4  green output
- blue  out  4  blue output
- LHBL_dly  out  1  LHBL delayed by BLANK_DLY pxl_cen ticks
- LVBL_dly  out  1  LVBL delayed by BLANK_DLY pxl_cen ticks

Behaviour:
- Reset: red = green = blue = 0, LHBL_dly = LVBL_dly = 0, pipeline index registers cleared to 0. Palette RAM contents are not reset.
- Transparency: a layer is transparent when col[2:0] == 0 or its gfx_en bit is 0. The scroll layer is never transparent except through gfx_en[2].
- Priority: char over obj over scroll.
- Index formation (8 bits):
  - char → {3'b000, char_pxl}, range 0x00–0x1F
  - obj → {3'b100, obj_pxl}, range 0x80–0x9F
  - scroll → {2'b11, scr_pxl}, range 0xC0–0xFF
  - all layers transparent (scroll disabled) → 0x00
- Stage 1: on pxl_cen, register the selected index into pal_idx.
- Stage 2: pal_idx drives the read address of both banks. The RAM has a 1-clk read latency, so data is valid well before the next pxl_cen.
- Stage 3: on pxl_cen, latch the RAM data:
  - red = rg[3:0], green = rg[7:4], blue = b[3:0]; b[7:4] is ignored.
  - If LHBL_dly or LVBL_dly (the values being output with this pixel) is 0, latch 0 instead.
- Latency: pixel presented at tick N appears on RGB after tick N+2.
- Blanking: LHBL/LVBL shift through a BLANK_DLY-deep register chain advanced only on pxl_cen.
- CPU port:
  - write when pal_cs & ~cpu_wrn, to bank cpu_addr[8] at address cpu_addr[7:0], on any clk edge; pxl_cen is irrelevant.
  - Reads return the addressed bank byte one clk after the address is stable.
- Simultaneous CPU write and video read of the same entry: the video side may return old or new data. No stall, no arbitration.
- pxl_cen low: all video-side registers hold. The CPU port stays active.
- Reset mid-line: outputs go to 0 immediately. The first valid pixel appears after 2 pxl_cen ticks following release.

Decomposition:
- Shared package constants:
  - layer base indices CHAR_BASE = 3'b000, OBJ_BASE = 3'b100, SCR_BASE = 2'b11
  - bank select bit position 8
  - transparent colour value 0
- Sub-modules: two instances of jtframe_dual_ram (aw = 8), one per bank. Port 0 is the CPU, port 1 is video read-only.
- The priority mux is a combinational block inside this module; no separate sub-module is needed.

Test Plan:
- CPU writes 0x5A to addr 0x013 and 0x0C to addr 0x113, then reads both → cpu_din = 0x5A, then 0x0C.
- With that entry loaded, char_pxl = 5'h13, obj = 5'h0A, scr = 6'h21, blanking inactive → after 2 pxl_cen ticks RGB = (A, 5, C) from palette entry 0x13.
- char_pxl = 0x10 (col 0), obj_pxl = 5'h0A, RG[0x8A] = 0x3F, B[0x18A] = 0x07 → RGB = (F, 3, 7); the object shows through.
- char = 0, obj = 0, scr_pxl = 6'h2B, RG[0xEB] = 0x21 → RGB = (1, 2, x). Then set gfx_en = 3'b011 → index 0x00 is used.
- LHBL driven low for 4 ticks → LHBL_dly goes low exactly 2 ticks later, and RGB = 0 for those 4 output ticks.
- Assert rst mid-line with RGB = (F, F, F) → RGB and LHBL_dly/LVBL_dly = 0 asynchronously. After release, the first valid pixel appears after the 2nd pxl_cen tick.
